// File: rtl/regwr_arbiter.sv
// Two-requester round-robin arbiter in front of a register-file write port.
// Define REGWR_ARB_FWD_EN to add the write-stage bypass ports.
module regwr_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [9:0]  req_rd,
  input  logic [63:0] req_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        grant_id,
  output logic [7:0]  x0_drop_cnt
`ifdef REGWR_ARB_FWD_EN
  ,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd_data
`endif
);

  logic [4:0]  rd_arr   [2];
  logic [31:0] data_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign rd_arr[gi]   = req_rd[5*gi +: 5];
      assign data_arr[gi] = req_data[32*gi +: 32];
    end
  endgenerate

  logic        rr_ptr_reg, rr_ptr_next;
  logic        wr_en_reg, wr_en_next;
  logic [4:0]  wr_addr_reg, wr_addr_next;
  logic [31:0] wr_data_reg, wr_data_next;
  logic        grant_id_reg, grant_id_next;
  logic [7:0]  drop_cnt_reg, drop_cnt_next;
  logic [1:0]  ready_next;
  logic        handshake;
  logic        sel;
  logic [4:0]  sel_rd;

  // Grant decision looks only at valids and the round-robin pointer.
  always_comb begin
    ready_next = 2'b00;
    if (!rst) begin
      case (req_valid)
        2'b01:   ready_next = 2'b01;
        2'b10:   ready_next = 2'b10;
        2'b11:   ready_next = rr_ptr_reg ? 2'b10 : 2'b01;
        default: ready_next = 2'b00;
      endcase
    end
  end

  assign req_ready = ready_next;
  assign handshake = |ready_next;
  assign sel       = ready_next[1];
  assign sel_rd    = rd_arr[sel];

  always_comb begin
    rr_ptr_next   = rr_ptr_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    grant_id_next = grant_id_reg;
    drop_cnt_next = drop_cnt_reg;
    if (handshake) begin
      wr_en_next    = (sel_rd != 5'd0);
      wr_addr_next  = sel_rd;
      wr_data_next  = data_arr[sel];
      grant_id_next = sel;
      // Writes to x0 are swallowed but still counted, saturating at 255.
      if (sel_rd == 5'd0 && drop_cnt_reg != 8'hFF)
        drop_cnt_next = drop_cnt_reg + 8'd1;
      if (req_valid == 2'b11)
        rr_ptr_next = ~rr_ptr_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg   <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= 5'd0;
      wr_data_reg  <= 32'd0;
      grant_id_reg <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      grant_id_reg <= grant_id_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign grant_id    = grant_id_reg;
  assign x0_drop_cnt = drop_cnt_reg;

`ifdef REGWR_ARB_FWD_EN
  // x0 never forwards since it reads as zero regardless of writes.
  assign fwd1_hit = wr_en_reg && (rs1_addr == wr_addr_reg) && (rs1_addr != 5'd0);
  assign fwd2_hit = wr_en_reg && (rs2_addr == wr_addr_reg) && (rs2_addr != 5'd0);
  assign fwd_data = wr_data_reg;
`endif

endmodule

// File: tb/tb_regwr_arbiter.sv
// Self-checking bench for regwr_arbiter: cycle model plus directed literal checks.
module tb_regwr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [9:0]  req_rd = 10'd0;
  logic [63:0] req_data = 64'd0;
  logic [1:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        grant_id;
  logic [7:0]  x0_drop_cnt;
`ifdef REGWR_ARB_FWD_EN
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd_data;
`endif

  regwr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .grant_id    (grant_id),
    .x0_drop_cnt (x0_drop_cnt)
`ifdef REGWR_ARB_FWD_EN
    ,
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit),
    .fwd_data    (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: favoured requester index, last write, drop count.
  int          m_ptr = 0;
  bit          m_wr_en = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_data = 32'd0;
  int          m_gid = 0;
  int          m_drop = 0;

  function automatic logic [1:0] model_ready();
    if (rst || req_valid == 2'b00) return 2'b00;
    if (req_valid == 2'b11) return (m_ptr == 1) ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  function automatic int grant_idx();
    logic [1:0] r;
    r = model_ready();
    return r[1] ? 1 : 0;
  endfunction

  function automatic int sel_rd();
    return (grant_idx() == 1) ? int'(req_rd[9:5]) : int'(req_rd[4:0]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr <= 0; m_wr_en <= 1'b0; m_addr <= 0; m_data <= 32'd0; m_gid <= 0; m_drop <= 0;
    end else if (model_ready() != 2'b00) begin
      m_wr_en <= (sel_rd() != 0);
      m_addr  <= sel_rd();
      m_data  <= (grant_idx() == 1) ? req_data[63:32] : req_data[31:0];
      m_gid   <= grant_idx();
      if (sel_rd() == 0 && m_drop < 255) m_drop <= m_drop + 1;
      if (req_valid == 2'b11) m_ptr <= 1 - m_ptr;
    end else begin
      m_wr_en <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("req_ready",   32'(req_ready),   32'(model_ready()));
      chk("wr_en",       32'(wr_en),       32'(m_wr_en));
      chk("wr_addr",     32'(wr_addr),     32'(m_addr));
      chk("wr_data",     wr_data,          m_data);
      chk("grant_id",    32'(grant_id),    32'(m_gid));
      chk("x0_drop_cnt", 32'(x0_drop_cnt), 32'(m_drop));
    end
  end

  task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_rd    = {r1, r0};
    req_data  = {d1, d0};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] patt;
    cyc(); cyc();
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    checking = 1'b1;

    // Both valid from reset: grants alternate 0,1,0,1.
    drive(2'b11, 5'd1, 5'd2, 32'hA0A0A0A0, 32'hB1B1B1B1);
    patt = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_grant", 32'(grant_id), 32'(patt[i]));
      chk("rr_wr_en", 32'(wr_en), 32'd1);
    end
    drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    cyc();
    chk("idle_wr_en", 32'(wr_en), 32'd0);
    chk("idle_hold_gid", 32'(grant_id), 32'd1);
    chk("idle_hold_data", wr_data, 32'hB1B1B1B1);

    // Single request from requester 0.
    drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
    #1;
    chk("single0_ready", 32'(req_ready), 32'd1);
    cyc();
    drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    chk("single0_wr_en", 32'(wr_en), 32'd1);
    chk("single0_addr", 32'(wr_addr), 32'd5);
    chk("single0_data", wr_data, 32'hDEADBEEF);
    chk("single0_gid", 32'(grant_id), 32'd0);

    // Single request from requester 1 leaves the pointer at 0.
    drive(2'b10, 5'd0, 5'd9, 32'd0, 32'h00000999);
    cyc();
    chk("single1_gid", 32'(grant_id), 32'd1);
    drive(2'b11, 5'd4, 5'd6, 32'h44, 32'h66);
    cyc();
    chk("ptr_kept_gid", 32'(grant_id), 32'd0);

    // Same destination from both: requester 1 first, then requester 0 wins last.
    drive(2'b11, 5'd3, 5'd3, 32'h111, 32'h222);
    cyc();
    chk("same_rd_first", wr_data, 32'h222);
    cyc();
    chk("same_rd_last", wr_data, 32'h111);
    drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    cyc();

    // Writes to x0 are dropped and the counter saturates.
    drive(2'b10, 5'd0, 5'd0, 32'd0, 32'h55);
    for (int i = 1; i <= 300; i++) begin
      cyc();
      if (i == 100) chk("x0_cnt_100", 32'(x0_drop_cnt), 32'd100);
      if (i == 1) chk("x0_wr_en", 32'(wr_en), 32'd0);
    end
    drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    cyc();
    chk("x0_cnt_sat", 32'(x0_drop_cnt), 32'd255);

    // Mid-stream reset while a write is on the port.
    drive(2'b01, 5'd10, 5'd0, 32'hCAFE, 32'd0);
    cyc();
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_cnt", 32'(x0_drop_cnt), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    drive(2'b11, 5'd1, 5'd2, 32'h11, 32'h22);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_gid", 32'(grant_id), 32'd0);
    chk("post_rst_addr", 32'(wr_addr), 32'd1);
    drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    cyc();

`ifdef REGWR_ARB_FWD_EN
    drive(2'b01, 5'd7, 5'd0, 32'h12, 32'd0);
    cyc();
    drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    #1;
    chk("fwd1_hit", 32'(fwd1_hit), 32'd1);
    chk("fwd2_hit", 32'(fwd2_hit), 32'd0);
    chk("fwd_data", fwd_data, 32'h12);
    rs2_addr = 5'd7;
    #1;
    chk("fwd2_hit_match", 32'(fwd2_hit), 32'd1);
    cyc();
    chk("fwd1_no_wr", 32'(fwd1_hit), 32'd0);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
`endif

    cyc();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
